hold_bus_arbiter: RTL and testbench

- Shares the 8088 local bus between the CPU and up to NUM_REQ bus masters (DMA channels, refresh engine).
- Requests the bus from the CPU with the HOLD/HLDA handshake, then grants it to one master at a time using fixed or round-robin priority.
- Bounds each master's tenure with a burst limit.
- Sits between the processor wrapper's hold/hlda pins and the DMA/refresh blocks; drives AEN for address-bus steering.

---
 rtl/hold_arb_pkg.sv | 21 ++
 rtl/arb_picker.sv | 36 +++
 rtl/hold_bus_arbiter.sv | 109 ++++++++++
 tb/tb_hold_bus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hold_arb_pkg.sv
// Shared definitions for the HOLD/HLDA bus arbiter: state encoding and default sizing.
package hold_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_BURST_MAX = 16;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_HREQ    = 3'd1;
  localparam logic [2:0] ENC_GRANT   = 3'd2;
  localparam logic [2:0] ENC_RELEASE = 3'd3;
  localparam logic [2:0] ENC_DROP    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ENC_IDLE,
    HREQ    = ENC_HREQ,
    GRANT   = ENC_GRANT,
    RELEASE = ENC_RELEASE,
    DROP    = ENC_DROP
  } arb_state_t;

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection: fixed (lowest index) or round-robin starting after rr_ptr.
module arb_picker
  import hold_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  input  logic                       rotate,
  output logic [NUM_REQ-1:0]         winner,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  int   cand;
  logic found;

  // Scan order starts at index 0 in fixed mode, or just past rr_ptr (wrapping) in rotate mode.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rotate) cand = (int'(rr_ptr) + 1 + k) % NUM_REQ;
      else        cand = k;
      if (!found && req[cand]) begin
        winner[cand] = 1'b1;
        idx          = IW'(cand);
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hold_bus_arbiter.sv
// Shares the 8088 local bus between the CPU and NUM_REQ masters via HOLD/HLDA, with burst-limited tenures.
module hold_bus_arbiter
  import hold_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rotate,
  input  logic               hlda,
  output logic               hold,
  output logic [NUM_REQ-1:0] grant,
  output logic               aen,
  output logic               err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

  arb_state_t           state;
  logic [IW-1:0]        rr_ptr;
  logic [CW-1:0]        burst_cnt;
  logic [CW-1:0]        cnt_next;
  logic [NUM_REQ-1:0]   win_oh;
  logic [IW-1:0]        win_idx;
  logic                 any_req;
  logic                 owner_req;
  logic                 others_req;
  logic                 limit_hit;

  arb_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .rotate (rotate),
    .winner (win_oh),
    .idx    (win_idx)
  );

  // cnt_next counts the GRANT cycle ending at this edge, so the limit fires after BURST_MAX cycles.
  assign cnt_next   = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CW'(1);
  assign any_req    = |req;
  assign owner_req  = |(req & grant);
  assign others_req = |(req & ~grant);
  assign limit_hit  = (cnt_next == CNT_MAX) && others_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      hold      <= 1'b0;
      grant     <= '0;
      aen       <= 1'b0;
      err       <= 1'b0;
      rr_ptr    <= IW'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= HREQ;
            hold  <= 1'b1;
          end
        end
        HREQ, RELEASE: begin
          // HREQ waits for the handshake; RELEASE already owns the bus and re-grants directly.
          if (hlda || state == RELEASE) begin
            if (any_req) begin
              state     <= GRANT;
              grant     <= win_oh;
              aen       <= 1'b1;
              rr_ptr    <= win_idx;
              burst_cnt <= '0;
            end else begin
              state <= DROP;
              hold  <= 1'b0;
            end
          end
        end
        GRANT: begin
          if (!hlda) begin
            err   <= 1'b1;
            state <= IDLE;
            hold  <= 1'b0;
            grant <= '0;
            aen   <= 1'b0;
          end else if (!owner_req || limit_hit) begin
            state <= RELEASE;
            grant <= '0;
            aen   <= 1'b0;
          end else begin
            burst_cnt <= cnt_next;
          end
        end
        DROP: begin
          if (!hlda) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          hold  <= 1'b0;
          grant <= '0;
          aen   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hold_bus_arbiter.sv
// Bench for hold_bus_arbiter: picker vector table, directed bus sequences, and random traffic vs a tenure model.
module tb_hold_bus_arbiter;

  localparam int N    = 4;
  localparam int BMAX = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic         rotate = 1'b0;
  logic         hlda = 1'b0;
  logic         hold;
  logic [N-1:0] grant;
  logic         aen;
  logic         err;

  logic [N-1:0] p_req = '0;
  logic [1:0]   p_ptr = '0;
  logic         p_rot = 1'b0;
  logic [N-1:0] p_win;
  logic [1:0]   p_idx;

  always #5 clk = ~clk;

  hold_bus_arbiter #(.NUM_REQ(N), .BURST_MAX(BMAX)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .rotate (rotate),
    .hlda   (hlda),
    .hold   (hold),
    .grant  (grant),
    .aen    (aen),
    .err    (err)
  );

  arb_picker #(.NUM_REQ(N)) pick_dut (
    .req    (p_req),
    .rr_ptr (p_ptr),
    .rotate (p_rot),
    .winner (p_win),
    .idx    (p_idx)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_bus();
    req = '0;
    tick();
    tick();
    hlda = 1'b0;
    tick();
    tick();
  endtask

  // Reference model: who owns the bus, whether the CPU is being asked/let go, and tenure length.
  int           m_owner = -1;
  int           m_ptr = N - 1;
  int           m_cnt = 0;
  bit           m_hold = 1'b0;
  bit           m_err = 1'b0;
  bit           m_asking = 1'b0;
  bit           m_gap = 1'b0;
  bit           m_leaving = 1'b0;
  logic [N-1:0] m_others;
  bit           chk_en = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input logic rot, input int ptr);
    int c;
    for (int k = 0; k < N; k++) begin
      c = rot ? (ptr + 1 + k) % N : k;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic take(input int w);
    if (w >= 0) begin
      m_owner = w;
      m_ptr   = w;
      m_cnt   = 0;
    end else begin
      m_leaving = 1'b1;
      m_hold    = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      m_owner = -1; m_ptr = N - 1; m_cnt = 0;
      m_hold = 1'b0; m_err = 1'b0;
      m_asking = 1'b0; m_gap = 1'b0; m_leaving = 1'b0;
    end else if (m_owner >= 0) begin
      if (!hlda) begin
        m_err = 1'b1; m_owner = -1; m_hold = 1'b0;
      end else begin
        m_cnt = (m_cnt < BMAX) ? m_cnt + 1 : BMAX;
        m_others = req;
        m_others[m_owner] = 1'b0;
        if (!req[m_owner] || (m_cnt == BMAX && m_others != '0)) begin
          m_owner = -1; m_gap = 1'b1;
        end
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
      take(pick(req, rotate, m_ptr));
    end else if (m_asking) begin
      if (hlda) begin
        m_asking = 1'b0;
        take(pick(req, rotate, m_ptr));
      end
    end else if (m_leaving) begin
      if (!hlda) m_leaving = 1'b0;
    end else if (req != '0) begin
      m_asking = 1'b1; m_hold = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_hold", {31'd0, hold}, {31'd0, m_hold});
      check("model_grant", {28'd0, grant}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("model_aen", {31'd0, aen}, {31'd0, (m_owner >= 0)});
      check("model_err", {31'd0, err}, {31'd0, m_err});
    end
  end

  typedef struct {
    logic [N-1:0] r;
    logic [1:0]   p;
    logic         rot;
    logic [N-1:0] w;
    logic [1:0]   i;
  } pv_t;

  pv_t pv[9];

  initial begin
    pv[0] = '{4'b0000, 2'd0, 1'b0, 4'b0000, 2'd0};
    pv[1] = '{4'b1010, 2'd0, 1'b0, 4'b0010, 2'd1};
    pv[2] = '{4'b1000, 2'd2, 1'b0, 4'b1000, 2'd3};
    pv[3] = '{4'b0101, 2'd3, 1'b0, 4'b0001, 2'd0};
    pv[4] = '{4'b1111, 2'd3, 1'b1, 4'b0001, 2'd0};
    pv[5] = '{4'b1111, 2'd0, 1'b1, 4'b0010, 2'd1};
    pv[6] = '{4'b1001, 2'd0, 1'b1, 4'b1000, 2'd3};
    pv[7] = '{4'b0001, 2'd0, 1'b1, 4'b0001, 2'd0};
    pv[8] = '{4'b0110, 2'd2, 1'b1, 4'b0010, 2'd1};

    for (int v = 0; v < 9; v++) begin
      p_req = pv[v].r; p_ptr = pv[v].p; p_rot = pv[v].rot;
      #1;
      check($sformatf("picker_win[%0d]", v), {28'd0, p_win}, {28'd0, pv[v].w});
      if (pv[v].w != '0) check($sformatf("picker_idx[%0d]", v), {30'd0, p_idx}, {30'd0, pv[v].i});
    end

    // Reset state
    tick();
    tick();
    check("rst_hold", {31'd0, hold}, 32'd0);
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_aen", {31'd0, aen}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;

    // Single request with hlda two cycles after hold
    req = 4'b0001;
    tick();
    check("single_hold", {31'd0, hold}, 32'd1);
    check("single_nogrant", {28'd0, grant}, 32'd0);
    tick();
    hlda = 1'b1;
    tick();
    check("single_grant", {28'd0, grant}, 32'b0001);
    check("single_aen", {31'd0, aen}, 32'd1);
    req = '0;
    tick();
    check("single_rel_grant", {28'd0, grant}, 32'd0);
    check("single_rel_hold", {31'd0, hold}, 32'd1);
    tick();
    check("single_drop_hold", {31'd0, hold}, 32'd0);
    hlda = 1'b0;
    tick();
    tick();
    check("single_idle_hold", {31'd0, hold}, 32'd0);

    // Fixed priority hand-over without releasing the CPU
    req = 4'b1000;
    tick();
    hlda = 1'b1;
    tick();
    check("fixed_first", {28'd0, grant}, 32'b1000);
    req = 4'b1010;
    tick();
    check("fixed_keep", {28'd0, grant}, 32'b1000);
    req = 4'b0010;
    tick();
    check("fixed_gap", {28'd0, grant}, 32'd0);
    check("fixed_gap_hold", {31'd0, hold}, 32'd1);
    tick();
    check("fixed_next", {28'd0, grant}, 32'b0010);
    check("fixed_next_hold", {31'd0, hold}, 32'd1);
    release_bus();

    // Round-robin over all four requesters from a fresh pointer
    rst = 1'b0;
    tick();
    rst = 1'b1;
    rotate = 1'b1;
    req = 4'b1111;
    tick();
    hlda = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_grant[%0d]", k), {28'd0, grant}, 32'd1 << (k % 4));
      tick();
      tick();
      check($sformatf("rr_hold[%0d]", k), {28'd0, grant}, 32'd1 << (k % 4));
      if (k < 4) begin
        req = 4'b1111 & ~(4'b0001 << (k % 4));
        tick();
        check($sformatf("rr_gap[%0d]", k), {28'd0, grant}, 32'd0);
        req = 4'b1111;
        tick();
      end
    end
    release_bus();

    // Burst preemption: owner 0 keeps requesting, requester 2 arrives in cycle 5
    req = 4'b0001;
    tick();
    hlda = 1'b1;
    tick();
    for (int c = 1; c <= BMAX; c++) begin
      check($sformatf("burst_cyc[%0d]", c), {28'd0, grant}, 32'b0001);
      if (c == 5) req = 4'b0101;
      tick();
    end
    check("burst_gap", {28'd0, grant}, 32'd0);
    tick();
    check("burst_next", {28'd0, grant}, 32'b0100);
    release_bus();

    // Protocol error: hlda vanishes during GRANT
    req = 4'b0010;
    tick();
    hlda = 1'b1;
    tick();
    check("err_pre_grant", {28'd0, grant}, 32'b0010);
    hlda = 1'b0;
    tick();
    check("err_set", {31'd0, err}, 32'd1);
    check("err_grant", {28'd0, grant}, 32'd0);
    check("err_aen", {31'd0, aen}, 32'd0);
    check("err_hold", {31'd0, hold}, 32'd0);
    req = '0;
    tick();
    tick();
    check("err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b0;
    tick();
    check("err_cleared", {31'd0, err}, 32'd0);
    rst = 1'b1;

    // Reset in the middle of a tenure with the request still up
    req = 4'b0100;
    tick();
    hlda = 1'b1;
    tick();
    check("mid_grant", {28'd0, grant}, 32'b0100);
    rst = 1'b0;
    tick();
    check("mid_rst_hold", {31'd0, hold}, 32'd0);
    check("mid_rst_grant", {28'd0, grant}, 32'd0);
    check("mid_rst_aen", {31'd0, aen}, 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rehold", {31'd0, hold}, 32'd1);
    tick();
    check("mid_regrant", {28'd0, grant}, 32'b0100);
    release_bus();

    // Random traffic with a lagging CPU, rare hlda glitches and rare resets
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 7) == 0) begin
        int b;
        b = $urandom_range(0, N - 1);
        req[b] = ~req[b];
      end
      if ($urandom_range(0, 49) == 0) rotate = ~rotate;
      if (hlda !== hold && $urandom_range(0, 1) == 1) hlda = hold;
      else if (hlda && hold && $urandom_range(0, 399) == 0) hlda = 1'b0;
      rst = ($urandom_range(0, 599) != 0);
      tick();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
